// File: rtl/kuuga_mem_pkg.sv
// kuuga_mem_pkg
// Shared widths and types for the kuuga two-requester BRAM arbiter.
// Holds the default address/data/byte-enable widths, the BRAM read
// latency, and the {valid, owner} record carried down the response
// pipeline so that responses can be routed back to the right requester.

package kuuga_mem_pkg;

    localparam int ADDR_WIDTH   = 16;
    localparam int DATA_WIDTH   = 32;
    localparam int BE_WIDTH     = DATA_WIDTH / 8;
    localparam int READ_LATENCY = 2;

    // Saturation ceiling for the contention counter
    localparam logic [15:0] CONFLICT_MAX = 16'hFFFF;

    // One response-pipeline stage: a transfer is in flight and which
    // requester it belongs to.
    typedef struct packed {
        logic valid;
        logic owner;
    } resp_stage_t;

endpackage

// File: rtl/kuuga_rr_arb2.sv
// kuuga_rr_arb2
// Two-way round-robin grant logic for the kuuga BRAM arbiter.
// Ports:
//   clk    - clock
//   reset  - asynchronous active-high reset
//   req    - per-requester request, bit n belongs to requester n
//   gnt    - combinational one-hot (or zero) grant
//   winner - index of the granted requester (0 when nothing is granted)
// A lone requester is granted immediately; on a tie the requester that
// was not granted last wins. last_grant resets to 1 so requester 0 wins
// the first tie after reset.

module kuuga_rr_arb2
    import kuuga_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       winner
);

    logic last_grant_q;
    logic last_grant_d;

    // Grant selection. Grants are forced low while reset is held so that
    // nothing reaches the BRAM during reset.
    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    assign winner = gnt[1];

    // Remember who was granted; idle cycles leave the history untouched.
    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt != 2'b00) begin
            last_grant_d = gnt[1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/kuuga_bram_arbiter.sv
// kuuga_bram_arbiter
// Shares one BRAM port between two requesters with round-robin
// arbitration and routes each response back to its owner.
// Ports:
//   clk, reset      - single clock (also the BRAM clock), async active-high reset
//   req/gnt         - per-requester request and combinational grant
//   addr/we/be/wdata- per-requester transfer fields, slice n for requester n
//   rvalid/rdata    - per-requester response valid, shared response data
//   bram_*          - BRAM port A (byte address; word shift done outside)
//   conflict_count  - saturating count of cycles with both requests high
// The response pipeline is READ_LATENCY stages deep so rvalid lines up
// with the BRAM output register; only a latency of 2 is supported.

module kuuga_bram_arbiter
    import kuuga_mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = kuuga_mem_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH   = kuuga_mem_pkg::DATA_WIDTH,
    parameter int READ_LATENCY = kuuga_mem_pkg::READ_LATENCY
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    req,
    output logic [1:0]                    gnt,
    input  logic [2*ADDR_WIDTH-1:0]       addr,
    input  logic [1:0]                    we,
    input  logic [2*(DATA_WIDTH/8)-1:0]   be,
    input  logic [2*DATA_WIDTH-1:0]       wdata,
    output logic [1:0]                    rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          bram_en,
    output logic [ADDR_WIDTH-1:0]         bram_addr,
    output logic [(DATA_WIDTH/8)-1:0]     bram_we,
    output logic [DATA_WIDTH-1:0]         bram_wrdata,
    input  logic [DATA_WIDTH-1:0]         bram_rddata,
    output logic [15:0]                   conflict_count
);

    localparam int BE_W = DATA_WIDTH / 8;

    logic        winner;
    resp_stage_t stage_q [READ_LATENCY];
    resp_stage_t stage_d [READ_LATENCY];
    logic [15:0] conflict_count_q;
    logic [15:0] conflict_count_d;

    kuuga_rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .gnt    (gnt),
        .winner (winner)
    );

    // BRAM port mux. With no grant the winner index is 0, so the address
    // and write data simply follow requester 0.
    always_comb begin
        bram_en     = (gnt != 2'b00);
        bram_addr   = addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
        bram_wrdata = wdata[winner*DATA_WIDTH +: DATA_WIDTH];
        bram_we     = '0;
        if (bram_en && we[winner]) begin
            bram_we = be[winner*BE_W +: BE_W];
        end
    end

    // Response pipeline: stage 0 captures the grant, later stages shift.
    // Writes travel too so every grant gets exactly one rvalid.
    always_comb begin
        stage_d[0].valid = (gnt != 2'b00);
        stage_d[0].owner = winner;
        for (int i = 1; i < READ_LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    // Route the last stage back to its owner; data is a straight
    // passthrough qualified by rvalid.
    always_comb begin
        rvalid = 2'b00;
        if (stage_q[READ_LATENCY-1].valid) begin
            rvalid[stage_q[READ_LATENCY-1].owner] = 1'b1;
        end
    end

    assign rdata = bram_rddata;

    // Contention counter, saturating rather than wrapping.
    always_comb begin
        conflict_count_d = conflict_count_q;
        if ((req == 2'b11) && (conflict_count_q != CONFLICT_MAX)) begin
            conflict_count_d = conflict_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_count_q <= '0;
        end else begin
            conflict_count_q <= conflict_count_d;
        end
    end

    assign conflict_count = conflict_count_q;

endmodule
